// File: rtl/de_stage_reg.sv
// rtl/de_stage_reg.sv - D/E pipeline register with load-use and MD-unit hazard stall.
// Optional DE_STALL_COUNT_EN adds a saturating stall_cnt output.
module de_stage_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] d_rt_val,
  input  logic [31:0] d_imm,
  input  logic        md_occupy,
  output logic [31:0] e_instr,
  output logic [31:0] e_pc,
  output logic [31:0] e_A1,
  output logic [31:0] e_A2,
  output logic [31:0] e_imm,
  output logic        stall_d,
`ifdef DE_STALL_COUNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic [1:0]  stall_cause
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] e_instr_q, e_pc_q, e_a1_q, e_a2_q, e_imm_q;
  logic [31:0] e_instr_d, e_pc_d, e_a1_d, e_a2_d, e_imm_d;

  logic [5:0]  d_op, d_func, e_op;
  logic [4:0]  e_dest;
  logic        md_class, reads_rs, reads_rt, e_is_load;
  logic        ld_stall, md_stall;

  always_comb begin
    d_op      = d_instr[31:26];
    d_func    = d_instr[5:0];
    e_op      = e_instr_q[31:26];
    e_dest    = e_instr_q[20:16];
    md_class  = (d_op == 6'b000000) &&
                (d_func inside {6'b011000, 6'b011001, 6'b011010, 6'b011011,
                                6'b010000, 6'b010010, 6'b010001, 6'b010011});
    reads_rs  = !(d_op inside {6'b000010, 6'b000011, 6'b001111});
    reads_rt  = d_op inside {6'b000000, 6'b000100, 6'b000101,
                             6'b101011, 6'b101001, 6'b101000};
    e_is_load = e_op inside {6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101};
    // A load targeting $0 produces nothing a consumer could wait for.
    ld_stall  = e_is_load && (e_dest != 5'd0) &&
                ((reads_rs && (d_instr[25:21] == e_dest)) ||
                 (reads_rt && (d_instr[20:16] == e_dest)));
    md_stall  = md_class && md_occupy;
    stall_d   = ld_stall | md_stall;
  end

  always_comb begin
    cause_d = {md_stall, ld_stall};
    if (stall_d) begin
      e_instr_d = NOP_INSTR;
      e_pc_d    = 32'd0;
      e_a1_d    = 32'd0;
      e_a2_d    = 32'd0;
      e_imm_d   = 32'd0;
    end else begin
      e_instr_d = d_instr;
      e_pc_d    = d_pc;
      e_a1_d    = d_rs_val;
      e_a2_d    = d_rt_val;
      e_imm_d   = d_imm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      cause_q   <= 2'b00;
      e_instr_q <= NOP_INSTR;
      e_pc_q    <= 32'd0;
      e_a1_q    <= 32'd0;
      e_a2_q    <= 32'd0;
      e_imm_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      e_instr_q <= e_instr_d;
      e_pc_q    <= e_pc_d;
      e_a1_q    <= e_a1_d;
      e_a2_q    <= e_a2_d;
      e_imm_q   <= e_imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stall_d)  state_d = HOLD;
      HOLD:    if (!stall_d) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // RUN implies the previous cycle had no stall, so the cause reads as none there.
  always_comb begin
    stall_cause = (state_q == HOLD) ? cause_q : 2'b00;
    e_instr     = e_instr_q;
    e_pc        = e_pc_q;
    e_A1        = e_a1_q;
    e_A2        = e_a2_q;
    e_imm       = e_imm_q;
  end

`ifdef DE_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= 32'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
